// File: rtl/axilite_reg_slave.sv
// rtl/axilite_reg_slave.sv - AXI4-Lite register bank with parallel register export
// Optional out-of-window SLVERR decode enabled by defining AXI_SLVERR_EN.
module axilite_reg_slave #(
    parameter int          NREG      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1faf_0000
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset,
    input  logic [31:0]          axi_awaddr,
    input  logic [2:0]           axi_awprot,
    input  logic                 axi_awvalid,
    output logic                 axi_awready,
    input  logic [31:0]          axi_wdata,
    input  logic [3:0]           axi_wstrb,
    input  logic                 axi_wvalid,
    output logic                 axi_wready,
    output logic [1:0]           axi_bresp,
    output logic                 axi_bvalid,
    input  logic                 axi_bready,
    input  logic [31:0]          axi_araddr,
    input  logic [2:0]           axi_arprot,
    input  logic                 axi_arvalid,
    output logic                 axi_arready,
    output logic [31:0]          axi_rdata,
    output logic [1:0]           axi_rresp,
    output logic                 axi_rvalid,
    input  logic                 axi_rready,
    output logic [32*NREG-1:0]   regs_out
);

    localparam int IW = $clog2(NREG);

    logic [31:0] r_regs [NREG];
    logic        r_aw_got;
    logic [31:0] r_awaddr;
    logic        r_w_got;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_commit;
    logic [31:0]   w_aw_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [IW-1:0] w_widx;
    logic [IW-1:0] w_ridx;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_unused;

    assign axi_awready = ~r_aw_got & ~r_bvalid;
    assign axi_wready  = ~r_w_got & ~r_bvalid;
    assign axi_arready = ~r_rvalid;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;

    assign w_aw_hs = axi_awvalid & axi_awready;
    assign w_w_hs  = axi_wvalid & axi_wready;
    assign w_ar_hs = axi_arvalid & axi_arready;

    // Commit as soon as both halves are present, whether latched earlier or arriving now.
    assign w_commit  = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    assign w_aw_addr = r_aw_got ? r_awaddr : axi_awaddr;
    assign w_wdata   = r_w_got ? r_wdata : axi_wdata;
    assign w_wstrb   = r_w_got ? r_wstrb : axi_wstrb;
    assign w_widx    = w_aw_addr[IW+1:2];
    assign w_ridx    = axi_araddr[IW+1:2];

`ifdef AXI_SLVERR_EN
    assign w_wr_ok = (w_aw_addr[31:IW+2] == BASE_ADDR[31:IW+2]);
    assign w_rd_ok = (axi_araddr[31:IW+2] == BASE_ADDR[31:IW+2]);
`else
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
`endif

    assign w_unused = ^{axi_awprot, axi_arprot, w_aw_addr, axi_araddr};

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_aw_got <= 1'b0;
            r_awaddr <= '0;
            r_w_got  <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (r_bvalid && axi_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit) begin
                r_aw_got <= 1'b0;
                r_w_got  <= 1'b0;
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
                if (w_wr_ok) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wstrb[b]) begin
                            r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_got <= 1'b1;
                    r_awaddr <= axi_awaddr;
                end
                if (w_w_hs) begin
                    r_w_got <= 1'b1;
                    r_wdata <= axi_wdata;
                    r_wstrb <= axi_wstrb;
                end
            end

            if (r_rvalid && axi_rready) begin
                r_rvalid <= 1'b0;
            end
            // Sampled before this edge's write lands, so a colliding read sees the old value.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_ok ? r_regs[w_ridx] : 32'h0;
                r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_out
        assign regs_out[32*g +: 32] = r_regs[g];
    end

endmodule
